mips32_decode_stage: RTL and testbench

Registered instruction-decode stage that produces the 3-bit alu_control code and operand steering consumed by the ALU. It sits between instruction fetch and the ALU/operand-read stage of the MIPS32 core. It takes one 32-bit instruction per valid/ready transfer and emits one decoded bundle per valid/ready transfer. It supports backpressure and a pipeline flush.

---
 rtl/mips32_pkg.sv | 37 +++
 rtl/mips32_alu_ctrl_dec.sv | 45 ++++
 rtl/mips32_decode_stage.sv | 70 +++++++
 tb/tb_mips32_decode_stage.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// mips32_pkg: opcode/funct/ALU-code constants and the decoded bundle type
package mips32_pkg;
    typedef logic [2:0] alu_control_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam alu_control_t ALU_ADD  = 3'b000;
    localparam alu_control_t ALU_SUB  = 3'b001;
    localparam alu_control_t ALU_AND  = 3'b010;
    localparam alu_control_t ALU_OR   = 3'b011;
    localparam alu_control_t ALU_XOR  = 3'b100;
    localparam alu_control_t ALU_SHL  = 3'b101;
    localparam alu_control_t ALU_SHR  = 3'b110;
    localparam alu_control_t ALU_NONE = 3'b111;
    typedef struct packed {
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   rd;
        alu_control_t alu;
        logic         a_sel;
        logic         b_sel;
        logic [31:0]  imm32;
        logic         reg_we;
        logic         illegal;
    } dec_t;
    localparam dec_t DEC_RST = '{rs: 5'd0, rt: 5'd0, rd: 5'd0, alu: ALU_NONE, a_sel: 1'b0,
                                 b_sel: 1'b0, imm32: 32'd0, reg_we: 1'b0, illegal: 1'b0};
endpackage

// File: rtl/mips32_alu_ctrl_dec.sv
// mips32_alu_ctrl_dec: combinational instruction-to-ALU-control decoder
import mips32_pkg::*;

module mips32_alu_ctrl_dec (
    input  logic [31:0] instr,
    output dec_t        d
);
    logic [5:0] op, fn;
    assign op = instr[31:26];
    assign fn = instr[5:0];
    always_comb begin
        d = '{rs: instr[25:21], rt: instr[20:16], rd: instr[20:16], alu: ALU_NONE, a_sel: 1'b0,
              b_sel: 1'b0, imm32: 32'd0, reg_we: 1'b0, illegal: 1'b1};
        case (op)
            OP_RTYPE: begin
                d.rd = instr[15:11];
                case (fn)
                    FN_ADD:  d.alu = ALU_ADD;
                    FN_SUB:  d.alu = ALU_SUB;
                    FN_AND:  d.alu = ALU_AND;
                    FN_OR:   d.alu = ALU_OR;
                    FN_XOR:  d.alu = ALU_XOR;
                    FN_SLL:  d.alu = ALU_SHL;
                    FN_SRL:  d.alu = ALU_SHR;
                    default: ;
                endcase
                d.illegal = d.alu == ALU_NONE;
                d.reg_we  = !d.illegal;
                // shifts operate on rt with shamt steered through the immediate path
                d.a_sel   = fn == FN_SLL || fn == FN_SRL;
                d.b_sel   = d.a_sel;
                d.imm32   = d.a_sel ? {27'd0, instr[10:6]} : 32'd0;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
                d.alu     = op == OP_ADDI ? ALU_ADD : op == OP_ANDI ? ALU_AND :
                            op == OP_ORI ? ALU_OR : ALU_XOR;
                d.b_sel   = 1'b1;
                d.reg_we  = 1'b1;
                d.illegal = 1'b0;
                d.imm32   = op == OP_ADDI ? {{16{instr[15]}}, instr[15:0]} : {16'd0, instr[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips32_decode_stage.sv
// mips32_decode_stage: registered decode stage with valid/ready handshake and flush.
// Define MIPS32_DECODE_ILLEGAL_CNT_EN to add the saturating illegal_cnt output.
import mips32_pkg::*;

module mips32_decode_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        alu_control,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    output logic [4:0]        rd_addr,
    output logic              a_sel,
    output logic              b_sel,
    output logic [DATA_W-1:0] imm32,
    output logic              reg_we,
    output logic              illegal
`ifdef MIPS32_DECODE_ILLEGAL_CNT_EN
    ,
    output logic [15:0]       illegal_cnt
`endif
);
    dec_t d, q;
    logic load;

    mips32_alu_ctrl_dec u_dec (.instr(in_instr), .d(d));

    assign in_ready = (!out_valid | out_ready) & !flush;
    assign load     = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= DEC_RST;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            q         <= d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MIPS32_DECODE_ILLEGAL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt <= 16'd0;
        else if (load && d.illegal && illegal_cnt != 16'hFFFF)
            illegal_cnt <= illegal_cnt + 16'd1;
    end
`endif

    assign alu_control = q.alu;
    assign rs_addr     = q.rs;
    assign rt_addr     = q.rt;
    assign rd_addr     = q.rd;
    assign a_sel       = q.a_sel;
    assign b_sel       = q.b_sel;
    assign imm32       = q.imm32;
    assign reg_we      = q.reg_we;
    assign illegal     = q.illegal;
endmodule

// File: tb/tb_mips32_decode_stage.sv
// tb_mips32_decode_stage: directed self-checking bench for the decode stage
module tb_mips32_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic        in_ready, out_valid, a_sel, b_sel, reg_we, illegal;
    logic [2:0]  alu_control;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] imm32;
    int          n_tests = 0;
    int          n_fail  = 0;
`ifdef MIPS32_DECODE_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    mips32_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .a_sel(a_sel), .b_sel(b_sel), .imm32(imm32), .reg_we(reg_we), .illegal(illegal)
`ifdef MIPS32_DECODE_ILLEGAL_CNT_EN
        , .illegal_cnt(illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = 32'd0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu", alu_control, 3'b111);
        chk("rst_addrs", {rs_addr, rt_addr, rd_addr}, 0);
        chk("rst_sel", {a_sel, b_sel}, 0);
        chk("rst_imm", imm32, 0);
        chk("rst_we_ill", {reg_we, illegal}, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        send(32'h00221820);
        chk("add_valid", out_valid, 1);
        chk("add_alu", alu_control, 3'b000);
        chk("add_regs", {rs_addr, rt_addr, rd_addr}, {5'd1, 5'd2, 5'd3});
        chk("add_bsel_we", {b_sel, reg_we, illegal}, 3'b010);
        send(32'h00221822);
        chk("sub_alu", alu_control, 3'b001);
        send(32'h2085FFFF);
        chk("addi_alu", alu_control, 3'b000);
        chk("addi_rd", rd_addr, 5);
        chk("addi_rs", rs_addr, 4);
        chk("addi_bsel", {a_sel, b_sel, reg_we}, 3'b011);
        chk("addi_imm", imm32, 32'hFFFFFFFF);
        send(32'h34068000);
        chk("ori_alu", alu_control, 3'b011);
        chk("ori_imm", imm32, 32'h00008000);
        chk("ori_rd", rd_addr, 6);
        send(32'h00031100);
        chk("sll_alu", alu_control, 3'b101);
        chk("sll_sel", {a_sel, b_sel, reg_we}, 3'b111);
        chk("sll_rt_rd", {rt_addr, rd_addr}, {5'd3, 5'd2});
        chk("sll_imm", imm32, 4);
        send(32'h000317C2);
        chk("srl_alu", alu_control, 3'b110);
        chk("srl_imm", imm32, 31);
        send(32'h00221824);
        chk("and_alu", alu_control, 3'b010);
        chk("and_sel", {a_sel, b_sel}, 0);
        send(32'h00221825);
        chk("or_alu", alu_control, 3'b011);
        send(32'h00221826);
        chk("xor_alu", alu_control, 3'b100);
        send(32'h00220020);
        chk("rd0_we", {rd_addr, reg_we}, {5'd0, 1'b1});
        send(32'h3085FFFF);
        chk("andi_alu", alu_control, 3'b010);
        chk("andi_imm", imm32, 32'h0000FFFF);
        send(32'h3885FFFF);
        chk("xori_alu", alu_control, 3'b100);
        chk("xori_imm", imm32, 32'h0000FFFF);

        out_ready = 1'b0;
        in_instr  = 32'h00221822;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_alu_hold", alu_control, 3'b100);
            chk("bp_imm_hold", imm32, 32'h0000FFFF);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        send(32'h00221822);
        chk("b2b_sub", {out_valid, alu_control}, {1'b1, 3'b001});
        send(32'h00221820);
        chk("b2b_add", {out_valid, alu_control}, {1'b1, 3'b000});

        send(32'hFC000000);
        chk("ill_flags", {out_valid, illegal, reg_we}, 3'b110);
        chk("ill_alu", alu_control, 3'b111);
        chk("ill_imm_bsel", {b_sel, imm32}, 0);
`ifdef MIPS32_DECODE_ILLEGAL_CNT_EN
        chk("ill_cnt", illegal_cnt, 1);
`endif
        flush = 1'b1;
        in_instr = 32'hFC000000;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_no_load", {alu_control, illegal}, {3'b111, 1'b1});
`ifdef MIPS32_DECODE_ILLEGAL_CNT_EN
        chk("flush_cnt", illegal_cnt, 1);
`endif
        flush = 1'b0;
        send(32'h0000003F);
        chk("ill_funct", {illegal, alu_control, reg_we}, {1'b1, 3'b111, 1'b0});
        in_valid = 1'b0;
        tick();
        chk("idle_drain", out_valid, 0);

        send(32'h00221820);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_alu", alu_control, 3'b111);
        chk("async_rst_we_ill", {reg_we, illegal}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
